pps_timekeeper: RTL and testbench
=================================

Name: pps_timekeeper

Overview:
- Parametrised successor to the single-PPS blink counter.
- A runtime-loadable NCO phase accumulator produces a 1 Hz pulse from any core clock, e.g. the PLL output.
- The pulse drives cascaded seconds/minutes/hours counters with carry ticks, a time-set port and a run/freeze control.
- Also provides LED-ready status outputs; sits directly behind the PLL in LED/clock demo tops.

Parameters:
- ACC_W, 32, phase accumulator width; pps = carry out of bit ACC_W-1.
- INC_DEFAULT, 172, increment loaded at reset (1 Hz at 25 MHz when ACC_W=32).
- SEC_MOD, 60, seconds modulus.
- MIN_MOD, 60, minutes modulus.
- HOUR_MOD, 24, hours modulus.

Ports:
- CLK  in  1  core clock (PLL output).
- RST  in  1  synchronous reset, active-high.
- run  in  1  1 = accumulator advances; 0 = accumulator and counters frozen.
- inc_load  in  1  load inc_value into the increment register.
- inc_value  in  ACC_W  new NCO increment.
- time_set  in  1  load set_* into the counters and clear the accumulator.
- set_sec  in  6  seconds value for time_set.
- set_min  in  6  minutes value for time_set.
- set_hour  in  5  hours value for time_set.
- pps  out  1  one-cycle pulse per accumulator wrap.
- min_tick  out  1  one-cycle pulse when seconds wrap to 0.
- hour_tick  out  1  one-cycle pulse when minutes wrap to 0.
- secs  out  6  current seconds.
- mins  out  6  current minutes.
- hours  out  5  current hours.
- led_phase  out  1  high while acc[ACC_W-1:ACC_W-2] == 2'b00 (25% duty blink).
- led_minute_n  out  1  low while secs == 0 (active-low LED).

Behaviour:
- Reset, synchronous:
  - acc = 0, inc = INC_DEFAULT.
  - pps = min_tick = hour_tick = 0.
  - secs = mins = hours = 0, so led_phase = 1 and led_minute_n = 0.
- Accumulator: each edge with run=1 and no time_set, {carry, acc} <= acc + inc (ACC_W+1-bit sum, wrap modulo 2^ACC_W); pps <= carry. With run=0, acc holds and pps <= 0.
- inc_load:
  - inc <= inc_value on that edge; the new value is first used on the next edge.
  - Simultaneous inc_load and time_set: both take effect.
- Counters update on the edge where the registered pps is 1, so they lag the pps assertion by one cycle:
  - secs == SEC_MOD-1: secs <= 0, min_tick <= 1; otherwise secs+1.
  - On min_tick-generating edge, mins == MIN_MOD-1: mins <= 0, hour_tick <= 1; otherwise mins+1.
  - On hour_tick-generating edge, hours == HOUR_MOD-1: hours <= 0; otherwise hours+1.
  - min_tick and hour_tick are single-cycle; both can assert on the same edge (xx:59:59 to 00:00:00 wrap).
- Out-of-range guard: any counter >= its modulus is forced to 0 on the next edge, with no tick. Same rule as the legacy secs >= 60 clamp.
- time_set has priority over pps:
  - Counters load set_*; any out-of-range set value loads 0.
  - acc <= 0, pps <= 0, ticks <= 0.
  - The next pps occurs one full period later.
- run=0 with a pending pps: the counters still consume that pps (already registered) but no new pps is generated.
- RST mid-second restores reset values on that edge regardless of other inputs.
- Period: pps interval = ceil(2^ACC_W / inc) or floor(2^ACC_W / inc) cycles; long-run average 2^ACC_W / inc exactly.
- inc = 0: pps never asserts; counters hold.

Optional Feature:
- Macro: PPS_TIMEKEEPER_ALARM_EN.
- Defined: extra ports alarm_min in 6, alarm_hour in 5, alarm_arm in 1, alarm out 1.
  - alarm is a registered one-cycle pulse on the edge where mins/hours become equal to alarm_min/alarm_hour via a min_tick or time_set, while alarm_arm=1.
  - alarm resets to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- RST, then inc_load with 32'h4000_0000, run=1 -> pps high exactly every 4th cycle; secs increments 1 cycle after each pps; led_phase high 1 of every 4 cycles.
- time_set with sec=58, min=59, hour=23, inc=32'h4000_0000 -> after 2 pps: secs=0, mins=0, hours=0; min_tick and hour_tick high on the same cycle; led_minute_n=0.
- time_set with sec=61, min=70, hour=30 -> all counters read 0 the next cycle; no ticks.
- Drop run to 0 mid-second for 10 cycles -> acc and counters frozen, no pps; on resume the pps interval is stretched by exactly 10 cycles.
- inc_load with 32'h8000_0000 on the same edge as time_set -> acc=0; first pps 2 cycles later, then every 2 cycles.
- Assert RST during the secs 59 to 0 carry cycle -> all outputs at reset values on the next cycle, no min_tick.
- ALARM_EN build: alarm_min=1, alarm_hour=0, armed, start at 00:00:59 -> alarm pulses for exactly 1 cycle with min_tick.

Source files
------------

// File: rtl/pps_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module   : pps_timekeeper
//  Purpose  : NCO-based 1 Hz pulse generator with cascaded seconds/minutes/
//             hours counters, a time-set port, run/freeze control and
//             LED-ready status outputs. Intended to sit directly behind the
//             PLL in LED/clock demo tops.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK          in   1      core clock (PLL output)
//    RST          in   1      synchronous reset, active-high
//    run          in   1      1 = accumulator advances, 0 = frozen
//    inc_load     in   1      load inc_value into the increment register
//    inc_value    in   ACC_W  new NCO increment
//    time_set     in   1      load set_* into counters, clear accumulator
//    set_sec      in   6      seconds value for time_set
//    set_min      in   6      minutes value for time_set
//    set_hour     in   5      hours value for time_set
//    pps          out  1      one-cycle pulse per accumulator wrap
//    min_tick     out  1      one-cycle pulse when seconds wrap to 0
//    hour_tick    out  1      one-cycle pulse when minutes wrap to 0
//    secs         out  6      current seconds
//    mins         out  6      current minutes
//    hours        out  5      current hours
//    led_phase    out  1      high while acc top two bits are 2'b00
//    led_minute_n out  1      low while secs == 0 (active-low LED)
//  Optional (macro PPS_TIMEKEEPER_ALARM_EN):
//    alarm_min    in   6      alarm minutes
//    alarm_hour   in   5      alarm hours
//    alarm_arm    in   1      alarm enable
//    alarm        out  1      registered one-cycle alarm pulse
// ============================================================================
module pps_timekeeper #(
   parameter int                 ACC_W       = 32,
   parameter logic [ACC_W-1:0]   INC_DEFAULT = 172,
   parameter int                 SEC_MOD     = 60,
   parameter int                 MIN_MOD     = 60,
   parameter int                 HOUR_MOD    = 24
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             run,
   input  logic             inc_load,
   input  logic [ACC_W-1:0] inc_value,
   input  logic             time_set,
   input  logic [5:0]       set_sec,
   input  logic [5:0]       set_min,
   input  logic [4:0]       set_hour,
`ifdef PPS_TIMEKEEPER_ALARM_EN
   input  logic [5:0]       alarm_min,
   input  logic [4:0]       alarm_hour,
   input  logic             alarm_arm,
   output logic             alarm,
`endif
   output logic             pps,
   output logic             min_tick,
   output logic             hour_tick,
   output logic [5:0]       secs,
   output logic [5:0]       mins,
   output logic [4:0]       hours,
   output logic             led_phase,
   output logic             led_minute_n
);

   // Moduli widened by one bit so a modulus equal to 2^width still compares
   // correctly against the counter value.
   localparam logic [6:0] SEC_MOD_C   = 7'(SEC_MOD);
   localparam logic [6:0] SEC_LAST_C  = 7'(SEC_MOD - 1);
   localparam logic [6:0] MIN_MOD_C   = 7'(MIN_MOD);
   localparam logic [6:0] MIN_LAST_C  = 7'(MIN_MOD - 1);
   localparam logic [5:0] HOUR_MOD_C  = 6'(HOUR_MOD);
   localparam logic [5:0] HOUR_LAST_C = 6'(HOUR_MOD - 1);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W:0]   sum;

   logic [5:0]       sec_nxt;
   logic [5:0]       min_nxt;
   logic [4:0]       hour_nxt;
   logic             sec_carry;
   logic             min_carry;

   logic [5:0]       set_sec_ok;
   logic [5:0]       set_min_ok;
   logic [4:0]       set_hour_ok;

   // Carry out of the top bit is the raw 1 Hz event.
   assign sum = {1'b0, acc} + {1'b0, inc};

   // Out-of-range preset values collapse to zero.
   assign set_sec_ok  = ({1'b0, set_sec}  >= SEC_MOD_C)  ? 6'd0 : set_sec;
   assign set_min_ok  = ({1'b0, set_min}  >= MIN_MOD_C)  ? 6'd0 : set_min;
   assign set_hour_ok = ({1'b0, set_hour} >= HOUR_MOD_C) ? 5'd0 : set_hour;

   // Counter cascade. The registered pps drives the seconds stage, so the
   // counters lag the pps assertion by one cycle. An out-of-range counter
   // is cleared without producing a carry.
   always_comb begin
      sec_nxt   = secs;
      min_nxt   = mins;
      hour_nxt  = hours;
      sec_carry = 1'b0;
      min_carry = 1'b0;

      if ({1'b0, secs} >= SEC_MOD_C) begin
         sec_nxt = 6'd0;
      end else if (pps) begin
         if ({1'b0, secs} == SEC_LAST_C) begin
            sec_nxt   = 6'd0;
            sec_carry = 1'b1;
         end else begin
            sec_nxt = secs + 6'd1;
         end
      end

      if ({1'b0, mins} >= MIN_MOD_C) begin
         min_nxt = 6'd0;
      end else if (sec_carry) begin
         if ({1'b0, mins} == MIN_LAST_C) begin
            min_nxt   = 6'd0;
            min_carry = 1'b1;
         end else begin
            min_nxt = mins + 6'd1;
         end
      end

      if ({1'b0, hours} >= HOUR_MOD_C) begin
         hour_nxt = 5'd0;
      end else if (min_carry) begin
         if ({1'b0, hours} == HOUR_LAST_C) begin
            hour_nxt = 5'd0;
         end else begin
            hour_nxt = hours + 5'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         acc       <= '0;
         inc       <= INC_DEFAULT;
         pps       <= 1'b0;
         min_tick  <= 1'b0;
         hour_tick <= 1'b0;
         secs      <= 6'd0;
         mins      <= 6'd0;
         hours     <= 5'd0;
      end else begin
         // Increment load is independent of time_set; both may act together.
         if (inc_load) begin
            inc <= inc_value;
         end

         if (time_set) begin
            acc       <= '0;
            pps       <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            secs      <= set_sec_ok;
            mins      <= set_min_ok;
            hours     <= set_hour_ok;
         end else begin
            if (run) begin
               acc <= sum[ACC_W-1:0];
               pps <= sum[ACC_W];
            end else begin
               pps <= 1'b0;
            end
            // A pps already registered is consumed even while frozen.
            secs      <= sec_nxt;
            mins      <= min_nxt;
            hours     <= hour_nxt;
            min_tick  <= sec_carry;
            hour_tick <= min_carry;
         end
      end
   end

`ifdef PPS_TIMEKEEPER_ALARM_EN
   logic alarm_hit;

   // Match is judged on the values the counters are about to take, so the
   // pulse lines up with the edge that makes them equal.
   always_comb begin
      alarm_hit = 1'b0;
      if (time_set) begin
         alarm_hit = (set_min_ok == alarm_min) && (set_hour_ok == alarm_hour);
      end else if (sec_carry) begin
         alarm_hit = (min_nxt == alarm_min) && (hour_nxt == alarm_hour);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         alarm <= 1'b0;
      end else begin
         alarm <= alarm_arm && alarm_hit;
      end
   end
`endif

   assign led_phase    = (acc[ACC_W-1 -: 2] == 2'b00);
   assign led_minute_n = (secs != 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_pps_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pps_timekeeper
//  Purpose  : Self-checking bench for pps_timekeeper. A table of per-cycle
//             input/expected-output records is applied one clock at a time,
//             followed by hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pps_timekeeper;

   logic        CLK = 1'b0;
   logic        RST;
   logic        run;
   logic        inc_load;
   logic [31:0] inc_value;
   logic        time_set;
   logic [5:0]  set_sec;
   logic [5:0]  set_min;
   logic [4:0]  set_hour;
   logic        pps;
   logic        min_tick;
   logic        hour_tick;
   logic [5:0]  secs;
   logic [5:0]  mins;
   logic [4:0]  hours;
   logic        led_phase;
   logic        led_minute_n;
`ifdef PPS_TIMEKEEPER_ALARM_EN
   logic [5:0]  alarm_min  = 6'd0;
   logic [4:0]  alarm_hour = 5'd0;
   logic        alarm_arm  = 1'b0;
   logic        alarm;
`endif

   int nvec  = 0;
   int nfail = 0;

   pps_timekeeper dut (
      .CLK          (CLK),
      .RST          (RST),
      .run          (run),
      .inc_load     (inc_load),
      .inc_value    (inc_value),
      .time_set     (time_set),
      .set_sec      (set_sec),
      .set_min      (set_min),
      .set_hour     (set_hour),
`ifdef PPS_TIMEKEEPER_ALARM_EN
      .alarm_min    (alarm_min),
      .alarm_hour   (alarm_hour),
      .alarm_arm    (alarm_arm),
      .alarm        (alarm),
`endif
      .pps          (pps),
      .min_tick     (min_tick),
      .hour_tick    (hour_tick),
      .secs         (secs),
      .mins         (mins),
      .hours        (hours),
      .led_phase    (led_phase),
      .led_minute_n (led_minute_n)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst;
      logic        run;
      logic        il;
      logic [31:0] ival;
      logic        ts;
      logic [5:0]  ss;
      logic [5:0]  sm;
      logic [4:0]  sh;
      logic [21:0] exp_out;  // {pps,min_tick,hour_tick,secs,mins,hours,led_phase,led_minute_n}
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rst_i, input logic run_i, input logic il_i,
                               input logic [31:0] ival_i, input logic ts_i,
                               input logic [5:0] ss_i, input logic [5:0] sm_i, input logic [4:0] sh_i,
                               input logic e_pps, input logic e_mt, input logic e_ht,
                               input logic [5:0] e_s, input logic [5:0] e_m, input logic [4:0] e_h,
                               input logic e_lp, input logic e_lmn);
      vec_t v;
      v.rst = rst_i; v.run = run_i; v.il = il_i; v.ival = ival_i; v.ts = ts_i;
      v.ss = ss_i; v.sm = sm_i; v.sh = sh_i;
      v.exp_out = {e_pps, e_mt, e_ht, e_s, e_m, e_h, e_lp, e_lmn};
      return v;
   endfunction

   task automatic drive(input logic rst_i, input logic run_i, input logic il_i,
                        input logic [31:0] ival_i, input logic ts_i,
                        input logic [5:0] ss_i, input logic [5:0] sm_i, input logic [4:0] sh_i);
      RST = rst_i; run = run_i; inc_load = il_i; inc_value = ival_i; time_set = ts_i;
      set_sec = ss_i; set_min = sm_i; set_hour = sh_i;
   endtask

   task automatic step;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic check(input string name, input int act, input int exp_v);
      nvec++;
      if (act !== exp_v) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   localparam logic [31:0] C4 = 32'h4000_0000;
   localparam logic [31:0] C8 = 32'h8000_0000;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [21:0] act;
      int          cnt;
      int          both;

      // ---------------- vector table ----------------
      // rst run il ival ts ss sm sh | pps mt ht secs mins hours lp lmn
      vq.push_back(mk(1,0,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,1,0)); // 0 reset
      vq.push_back(mk(0,0,1,C4,0, 0, 0, 0, 0,0,0, 0, 0, 0,1,0)); // 1 load inc, frozen
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,0,0)); // 2 acc=4..
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,0,0)); // 3 acc=8..
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,0,0)); // 4 acc=C..
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0, 0, 0, 0,1,0)); // 5 wrap -> pps
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 1, 0, 0,0,1)); // 6 secs=1
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 1, 0, 0,0,1)); // 7
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 1, 0, 0,0,1)); // 8
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0, 1, 0, 0,1,1)); // 9 pps
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 2, 0, 0,0,1)); // 10 secs=2
      vq.push_back(mk(0,1,0,0 ,1,58,59,23, 0,0,0,58,59,23,1,1)); // 11 set 23:59:58
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,58,59,23,0,1)); // 12
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,58,59,23,0,1)); // 13
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,58,59,23,0,1)); // 14
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0,58,59,23,1,1)); // 15 pps one period after set
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,59,59,23,0,1)); // 16
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,59,59,23,0,1)); // 17
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,59,59,23,0,1)); // 18
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0,59,59,23,1,1)); // 19 pps
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,1,1, 0, 0, 0,0,0)); // 20 full wrap, both ticks
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,0,0)); // 21 ticks single-cycle
      vq.push_back(mk(0,1,0,0 ,1, 5, 6, 7, 0,0,0, 5, 6, 7,1,1)); // 22 set 07:06:05
      vq.push_back(mk(0,1,0,0 ,1,61,62,30, 0,0,0, 0, 0, 0,1,0)); // 23 out-of-range set
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,0,0)); // 24 acc=4..
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,0,0)); // 25 acc=8..
      for (int i = 0; i < 10; i++)                                // 26-35 frozen
         vq.push_back(mk(0,0,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,0,0));
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,0,0)); // 36 acc=C..
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0, 0, 0, 0,1,0)); // 37 pps 10 cycles late
      vq.push_back(mk(0,0,0,0 ,0, 0, 0, 0, 0,0,0, 1, 0, 0,1,1)); // 38 frozen, pending pps consumed
      vq.push_back(mk(0,1,1,C8,1,10,20, 3, 0,0,0,10,20, 3,1,1)); // 39 inc_load + time_set
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,10,20, 3,0,1)); // 40 acc=8..
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0,10,20, 3,1,1)); // 41 pps after 2
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,11,20, 3,0,1)); // 42
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0,11,20, 3,1,1)); // 43 pps every 2
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,12,20, 3,0,1)); // 44
      vq.push_back(mk(0,1,0,0 ,1,59,10, 5, 0,0,0,59,10, 5,1,1)); // 45 set 05:10:59
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,59,10, 5,0,1)); // 46
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0,59,10, 5,1,1)); // 47 pps
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,1,0, 0,11, 5,0,0)); // 48 min_tick only
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0, 0,11, 5,1,0)); // 49
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 1,11, 5,0,1)); // 50
      vq.push_back(mk(0,1,0,0 ,1,59,59,23, 0,0,0,59,59,23,1,1)); // 51 set 23:59:59
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0,59,59,23,0,1)); // 52
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 1,0,0,59,59,23,1,1)); // 53 pps pending
      vq.push_back(mk(1,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,1,0)); // 54 RST wins the carry
      vq.push_back(mk(0,1,0,0 ,0, 0, 0, 0, 0,0,0, 0, 0, 0,1,0)); // 55 default inc, acc small

      drive(1,0,0,0,0,0,0,0);
      repeat (3) @(negedge CLK);

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].run, vq[i].il, vq[i].ival, vq[i].ts, vq[i].ss, vq[i].sm, vq[i].sh);
         step();
         act = {pps, min_tick, hour_tick, secs, mins, hours, led_phase, led_minute_n};
         nvec++;
         if (act !== vq[i].exp_out) begin
            nfail++;
            $display("FAIL vec%0d: got %h, expected %h (pps,mt,ht,s,m,h,lp,lmn)",
                     i, act, vq[i].exp_out);
         end
      end

      // ------- non-power-of-two increment: 30 edges of 2^32/3 (+2/3) -------
      // Carries land on edges 3,6,...,30 -> 10 pps; the last is not yet consumed.
      drive(0,1,1,32'h5555_5556,1,0,0,0);
      step();
      drive(0,1,0,0,0,0,0,0);
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (pps) cnt++;
      end
      check("nco_third_pps_count", cnt, 10);
      check("nco_third_secs", int'(secs), 9);

      // ------- zero increment: no pps, counters hold -------
      drive(0,1,1,32'h0,1,33,0,0);
      step();
      drive(0,1,0,0,0,0,0,0);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (pps) cnt++;
      end
      check("inc_zero_pps_count", cnt, 0);
      check("inc_zero_secs", int'(secs), 33);

`ifdef PPS_TIMEKEEPER_ALARM_EN
      // ------- alarm at 00:01, starting from 00:00:59 -------
      alarm_min = 6'd1; alarm_hour = 5'd0; alarm_arm = 1'b1;
      drive(0,1,1,C8,1,59,0,0);
      step();
      check("alarm_after_set", int'(alarm), 0);
      drive(0,1,0,0,0,0,0,0);
      cnt = 0; both = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (alarm) cnt++;
         if (alarm && min_tick) both++;
      end
      check("alarm_pulse_count", cnt, 1);
      check("alarm_with_min_tick", both, 1);
`else
      both = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire
